direction_conditioner: RTL and testbench

Conditions the four raw active-low direction pushbuttons into clean, one-clock move pulses for the maze input stage that consumes `player_direction`. Per key: 2-flop synchronisation and counter debounce. A shared FSM then emits one pulse per accepted press, plus auto-repeat while a single key is held. It rejects chords, is gated by a game-enable level, and keeps a running count of emitted moves.

---
 rtl/direction_conditioner.sv | 155 +++++++++++++++
 tb/tb_direction_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/direction_conditioner.sv
// Pushbutton conditioner: per-key sync + debounce feeding a shared
// press/auto-repeat FSM that emits one-hot move pulses.
module direction_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 20000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  keys_n,
    input  logic        enable,
    output logic [3:0]  player_direction,
    output logic        held,
    output logic [15:0] move_count
);

    localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MAXRP = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int TW    = $clog2(MAXRP + 1);

    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] RMAX = TW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] PMAX = TW'(REPEAT_PERIOD_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_stable;
    logic [3:0]    r_stable_d;
    logic [CW-1:0] r_cnt [4];

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_key;
    logic [3:0]    r_dir;
    logic          r_held;
    logic [15:0]   r_count;

    logic [3:0]    w_rise;
    logic          w_rise_one;
    logic [1:0]    w_rise_idx;
    logic [3:0]    w_key_mask;
    logic [3:0]    w_others;
    logic [1:0]    w_next;
    logic [TW-1:0] w_timer_next;
    logic [1:0]    w_key_next;
    logic [3:0]    w_pulse;

    // A key's stable state flips only after DMAX+1 consecutive disagreeing samples
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1    <= ~keys_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_cnt[i] == DMAX) begin
                        r_stable[i] <= ~r_stable[i];
                        r_cnt[i]    <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_rise     = r_stable & ~r_stable_d;
    assign w_rise_one = (w_rise != 4'd0) && ((w_rise & (w_rise - 4'd1)) == 4'd0);
    assign w_key_mask = 4'b0001 << r_key;
    assign w_others   = r_stable & ~w_key_mask;

    always_comb begin
        w_rise_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_rise[i]) w_rise_idx = 2'(i);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_timer_next = '0;
        w_key_next   = r_key;
        w_pulse      = 4'd0;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rise != 4'd0) begin
                        if (w_rise_one && ((r_stable & ~w_rise) == 4'd0)) begin
                            w_pulse    = w_rise;
                            w_key_next = w_rise_idx;
                            w_next     = S_DELAY;
                        end else begin
                            w_next = S_LOCKED;
                        end
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (!r_stable[r_key]) begin
                        w_next = S_IDLE;
                    end else if (w_others != 4'd0) begin
                        w_next = S_LOCKED;
                    end else if (r_timer == ((r_state == S_DELAY) ? RMAX : PMAX)) begin
                        w_pulse = w_key_mask;
                        w_next  = S_REPEAT;
                    end else begin
                        w_timer_next = r_timer + TW'(1);
                    end
                end
                S_LOCKED: begin
                    if (r_stable == 4'd0) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_key   <= 2'd0;
            r_dir   <= 4'd0;
            r_held  <= 1'b0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_next;
            r_key   <= w_key_next;
            r_dir   <= w_pulse;
            r_held  <= (r_state == S_DELAY) || (r_state == S_REPEAT);
            if (r_dir != 4'd0) r_count <= r_count + 16'd1;
        end
    end

    assign player_direction = r_dir;
    assign held             = r_held;
    assign move_count       = r_count;

endmodule

// File: tb/tb_direction_conditioner.sv
// Scoreboard bench for direction_conditioner: a slow-repeat instance
// checked pulse-by-pulse, plus a R=P=1 instance for counter wrap and reset.
module tb_direction_conditioner;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  keys_n;
    logic        enable;
    logic [3:0]  player_direction;
    logic        held;
    logic [15:0] move_count;

    logic        f_reset;
    logic [3:0]  f_keys_n;
    logic        f_enable;
    logic [3:0]  f_dir;
    logic        f_held;
    logic [15:0] f_count;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        logic [3:0] dir;
        int         e;
    } exp_t;
    exp_t q[$];

    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    direction_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY_CYCLES(20),
        .REPEAT_PERIOD_CYCLES(8)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .keys_n(keys_n),
        .enable(enable),
        .player_direction(player_direction),
        .held(held),
        .move_count(move_count)
    );

    direction_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY_CYCLES(1),
        .REPEAT_PERIOD_CYCLES(1)
    ) u_fast (
        .clock(clock),
        .reset(f_reset),
        .keys_n(f_keys_n),
        .enable(f_enable),
        .player_direction(f_dir),
        .held(f_held),
        .move_count(f_count)
    );

    // Monitor: every pulse must match the head of the expectation queue
    always @(negedge clock) begin
        exp_t x;
        while (q.size() > 0 && q[0].e < edge_n) begin
            checks++;
            failures++;
            $display("FAIL missing_pulse got=none exp dir=%b at edge %0d",
                     q[0].dir, q[0].e);
            void'(q.pop_front());
        end
        if (player_direction != 4'd0) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse got dir=%b at edge %0d exp=none",
                         player_direction, edge_n);
            end else begin
                x = q.pop_front();
                if (x.dir != player_direction || x.e != edge_n) begin
                    failures++;
                    $display("FAIL pulse got dir=%b edge=%0d exp dir=%b edge=%0d",
                             player_direction, edge_n, x.dir, x.e);
                end
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic expect_at(input logic [3:0] d, input int e);
        exp_t x;
        x.dir = d;
        x.e   = e;
        q.push_back(x);
    endtask

    // Press key i now; first pulse lands D+3 edges later
    task automatic press(input int i);
        keys_n[i] = 1'b0;
        expect_at(4'b0001 << i, edge_n + D + 3);
    endtask

    initial begin
        int k;
        int j;
        reset    = 1'b1;
        keys_n   = 4'hF;
        enable   = 1'b1;
        f_reset  = 1'b1;
        f_keys_n = 4'hF;
        f_enable = 1'b1;
        wait_n(3);
        chk("reset_dir", 32'(player_direction), 32'd0);
        chk("reset_held", 32'(held), 32'd0);
        chk("reset_count", 32'(move_count), 32'd0);
        reset = 1'b0;
        wait_n(5);

        // Single clean press, released before repeat
        press(2);
        wait_n(10);
        keys_n[2] = 1'b1;
        wait_n(20);
        chk("t1_count", 32'(move_count), 32'd1);
        chk("t1_held", 32'(held), 32'd0);

        // Long hold: first pulse then auto-repeat
        k = edge_n;
        press(0);
        expect_at(4'b0001, k + 27);
        expect_at(4'b0001, k + 35);
        expect_at(4'b0001, k + 43);
        expect_at(4'b0001, k + 51);
        expect_at(4'b0001, k + 59);
        wait_n(30);
        chk("t2_held_mid", 32'(held), 32'd1);
        wait_n(30);
        keys_n[0] = 1'b1;
        wait_n(15);
        chk("t2_count", 32'(move_count), 32'd7);
        chk("t2_held_after", 32'(held), 32'd0);

        // Bounce shorter than D must be ignored
        for (int t = 0; t < 15; t++) begin
            keys_n[1] = ~keys_n[1];
            wait_n(2);
        end
        keys_n[1] = 1'b1;
        wait_n(15);
        chk("t3_count", 32'(move_count), 32'd7);

        // Chord during DELAY locks out further pulses
        press(0);
        wait_n(12);
        keys_n[3] = 1'b0;
        wait_n(10);
        keys_n[3] = 1'b1;
        wait_n(15);
        chk("t4_locked_held", 32'(held), 32'd0);
        keys_n[0] = 1'b1;
        wait_n(15);
        press(3);
        wait_n(10);
        keys_n[3] = 1'b1;
        wait_n(15);
        chk("t4_count", 32'(move_count), 32'd9);

        // Key held across enable rising gives nothing
        enable    = 1'b0;
        keys_n[1] = 1'b0;
        wait_n(15);
        enable = 1'b1;
        wait_n(30);
        chk("t5_no_pulse_count", 32'(move_count), 32'd9);
        keys_n[1] = 1'b1;
        wait_n(15);
        k = edge_n;
        press(1);
        expect_at(4'b0010, k + 27);
        expect_at(4'b0010, k + 35);
        wait_n(38);
        enable = 1'b0;
        wait_n(3);
        chk("t5_held_disabled", 32'(held), 32'd0);
        wait_n(12);
        keys_n[1] = 1'b1;
        wait_n(10);
        enable = 1'b1;
        wait_n(5);
        chk("t5_count", 32'(move_count), 32'd12);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d pending exp=0", q.size());
        end

        // Fast instance: one pulse per cycle until the counter wraps
        f_reset = 1'b0;
        wait_n(2);
        k = edge_n;
        f_keys_n[0] = 1'b0;
        wait_n(D + 2);
        chk("f_before_first", 32'(f_dir), 32'd0);
        wait_n(1);
        chk("f_first_dir", 32'(f_dir), 32'd1);
        chk("f_first_count", 32'(f_count), 32'd0);
        wait_n(65535);
        chk("f_count_max", 32'(f_count), 32'd65535);
        chk("f_held", 32'(f_held), 32'd1);
        wait_n(1);
        chk("f_count_wrap", 32'(f_count), 32'd0);
        j = edge_n;
        f_reset = 1'b1;
        wait_n(1);
        chk("f_rst_dir", 32'(f_dir), 32'd0);
        chk("f_rst_held", 32'(f_held), 32'd0);
        chk("f_rst_count", 32'(f_count), 32'd0);
        f_reset = 1'b0;
        wait_n(D + 2);
        chk("f_post_rst_quiet", 32'(f_dir), 32'd0);
        wait_n(1);
        chk("f_post_rst_pulse", 32'(f_dir), 32'd1);
        chk("f_post_rst_edge", 32'(edge_n - j), 32'(D + 4));
        wait_n(1);
        chk("f_post_rst_count", 32'(f_count), 32'd1);
        chk("f_post_rst_repeat", 32'(f_dir), 32'd1);
        f_keys_n[0] = 1'b1;
        wait_n(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
